// File: rtl/booth_divider.sv
// Sequential signed divider: radix-2 restoring division on operand magnitudes,
// followed by a sign-correction step, with a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; results from the last operation held
// CALC  | one restoring iteration per clock, WIDTH iterations
// SIGN  | apply operand signs and register quotient/remainder
// DONE  | one-cycle done pulse; start here chains a new operation
module booth_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] d_mag;
  logic [WIDTH:0]   rem;
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic             neg_r;

  logic             accept;
  logic             zero_div;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  assign accept   = start && (state == IDLE || state == DONE);
  assign zero_div = (divisor == '0);
  assign shifted  = {rem[WIDTH-1:0], q_mag[WIDTH-1]};
  assign diff     = shifted - {1'b0, d_mag};

  assign busy = (state == CALC) || (state == SIGN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = zero_div ? DONE : CALC;
      CALC: if (cnt == LAST) state_nxt = SIGN;
      SIGN: state_nxt = DONE;
      DONE: begin
        if (accept) state_nxt = zero_div ? DONE : CALC;
        else        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_mag       <= '0;
      d_mag       <= '0;
      rem         <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (accept) begin
      neg_q       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r       <= dividend[WIDTH-1];
      q_mag       <= dividend[WIDTH-1] ? -dividend : dividend;
      d_mag       <= divisor[WIDTH-1] ? -divisor : divisor;
      rem         <= '0;
      cnt         <= '0;
      div_by_zero <= zero_div;
      overflow    <= 1'b0;
      if (zero_div) begin
        quotient  <= '1;
        remainder <= dividend;
      end
    end else if (state == CALC) begin
      cnt <= cnt + CW'(1);
      if (!diff[WIDTH]) begin
        rem   <= diff;
        q_mag <= {q_mag[WIDTH-2:0], 1'b1};
      end else begin
        rem   <= shifted;
        q_mag <= {q_mag[WIDTH-2:0], 1'b0};
      end
    end else if (state == SIGN) begin
      quotient  <= neg_q ? -q_mag : q_mag;
      remainder <= neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
      // A positive-signed magnitude of 2^(WIDTH-1) only arises from MIN / -1.
      overflow  <= !neg_q && q_mag[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_booth_divider.sv
// Bench for booth_divider: directed vector table, multi-cycle corner sequences,
// and randomized operands checked against an arithmetic reference model.
module tb_booth_divider;

  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  booth_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .quotient(quotient),
    .remainder(remainder),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
    int           lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz, output logic ov);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    dz = 1'b0;
    ov = 1'b0;
    if (sb == 0) begin
      q  = '1;
      r  = a;
      dz = 1'b1;
    end else if (sa == -(1 << (W - 1)) && sb == -1) begin
      q  = a;
      r  = '0;
      ov = 1'b1;
    end else begin
      q = W'(sa / sb);
      r = W'(sa % sb);
    end
  endfunction

  // Called at a negedge. Returns the edge index (relative to acceptance edge)
  // at which done is sampled high, or 0 on timeout. Optionally drives a start
  // pulse sampled at edge k+ig_n, which the busy DUT must ignore.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int ig_n, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        output int lat, output logic busy_ok);
    logic dzero;
    logic exp_busy;
    dzero    = (b == '0);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1 start = 1'b0;
    lat     = 0;
    busy_ok = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      exp_busy = !dzero && (n <= W + 1);
      if (busy !== exp_busy) busy_ok = 1'b0;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      start = (n == ig_n);
      if (n == ig_n) begin
        dividend = ia;
        divisor  = ib;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] q, input logic [W-1:0] r,
                              input logic dz, input logic ov, input int exp_lat,
                              input int lat, input logic busy_ok);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " quotient"}, 32'(quotient), 32'(q));
    chk({tag, " remainder"}, 32'(remainder), 32'(r));
    chk({tag, " div_by_zero"}, 32'(div_by_zero), 32'(dz));
    chk({tag, " overflow"}, 32'(overflow), 32'(ov));
    chk({tag, " busy window"}, 32'(busy_ok), 32'd1);
  endtask

  vec_t vecs[$];

  initial begin
    int          lat;
    logic        bok;
    logic        stray;
    logic [W-1:0] a, b, eq, er;
    logic        edz, eov;

    vecs.push_back('{16'd100,  16'd7,     16'h000E, 16'h0002, 1'b0, 1'b0, 18});
    vecs.push_back('{16'hFF9C, 16'd7,     16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 18});
    vecs.push_back('{16'd100,  16'hFFF9,  16'hFFF2, 16'h0002, 1'b0, 1'b0, 18});
    vecs.push_back('{16'hFF9C, 16'hFFF9,  16'h000E, 16'hFFFE, 1'b0, 1'b0, 18});
    vecs.push_back('{16'd1234, 16'd0,     16'hFFFF, 16'h04D2, 1'b1, 1'b0, 1});
    vecs.push_back('{16'd10,   16'd3,     16'h0003, 16'h0001, 1'b0, 1'b0, 18});
    vecs.push_back('{16'h8000, 16'hFFFF,  16'h8000, 16'h0000, 1'b0, 1'b1, 18});
    vecs.push_back('{16'h8000, 16'h0002,  16'hC000, 16'h0000, 1'b0, 1'b0, 18});
    vecs.push_back('{16'd0,    16'd5,     16'h0000, 16'h0000, 1'b0, 1'b0, 18});
    vecs.push_back('{16'd5,    16'h8000,  16'h0000, 16'h0005, 1'b0, 1'b0, 18});
    vecs.push_back('{16'h8000, 16'h8000,  16'h0001, 16'h0000, 1'b0, 1'b0, 18});
    vecs.push_back('{16'h7FFF, 16'd1,     16'h7FFF, 16'h0000, 1'b0, 1'b0, 18});
    vecs.push_back('{16'h8000, 16'd0,     16'hFFFF, 16'h8000, 1'b1, 1'b0, 1});

    reset    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", {quotient, remainder}, 32'd0);
    chk("reset flags", {28'd0, busy, done, div_by_zero, overflow}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, 0, '0, '0, lat, bok);
      check_result($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ov,
                   vecs[i].lat, lat, bok);
      @(negedge clk);
      chk($sformatf("vec%0d done pulse width", i), 32'(done), 32'd0);
    end

    // Start while busy is ignored; start in the DONE cycle chains directly.
    run_op(16'd100, 16'd7, 5, 16'd50, 16'd5, lat, bok);
    check_result("ignored start", 16'h000E, 16'h0002, 1'b0, 1'b0, 18, lat, bok);
    run_op(16'd9, 16'd4, 0, '0, '0, lat, bok);
    check_result("chained start", 16'h0002, 16'h0001, 1'b0, 1'b0, 18, lat, bok);
    @(negedge clk);

    // Reset in the middle of an operation.
    start    = 1'b1;
    dividend = 16'd1000;
    divisor  = 16'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("midreset outputs", {quotient, remainder}, 32'd0);
    chk("midreset flags", {28'd0, busy, done, div_by_zero, overflow}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    stray = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) stray = 1'b1;
    end
    chk("no done after abort", 32'(stray), 32'd0);
    run_op(16'd1000, 16'd3, 0, '0, '0, lat, bok);
    check_result("after abort", 16'h014D, 16'h0001, 1'b0, 1'b0, 18, lat, bok);
    @(negedge clk);

    for (int i = 0; i < 300; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      case ($urandom_range(0, 15))
        0: b = '0;
        1: begin a = 16'h8000; b = 16'hFFFF; end
        2: a = 16'h8000;
        3: b = W'($urandom_range(1, 9));
        4: a = '0;
        default: ;
      endcase
      model(a, b, eq, er, edz, eov);
      run_op(a, b, 0, '0, '0, lat, bok);
      check_result($sformatf("rand%0d %h/%h", i, a, b), eq, er, edz, eov,
                   edz ? 1 : W + 2, lat, bok);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_divider.md
Name: booth_divider

Overview:
- Sequential signed integer divider: the inverse operation of the Booth multiplier datapath, in the same arithmetic subsystem.
- Takes a WIDTH-bit two's-complement dividend and divisor and returns quotient and remainder.
- Uses radix-2 restoring division on operand magnitudes, then applies a sign-correction step.
- Controlled by a start/busy/done handshake, like the multiplier controller.

Parameters:
- WIDTH, 16, operand and result width in bits (two's complement).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a divide; sampled on the rising edge of clk.
- dividend  input  WIDTH  signed dividend; captured on an accepted start.
- divisor  input  WIDTH  signed divisor; captured on an accepted start.
- quotient  output  WIDTH  signed quotient, truncated toward zero.
- remainder  output  WIDTH  signed remainder; carries the dividend's sign.
- busy  output  1  high while a divide is in progress.
- done  output  1  one-cycle pulse; results are valid from this cycle on.
- div_by_zero  output  1  set when the divisor captured for the current result was 0.
- overflow  output  1  set for the most-negative value divided by -1.

Behaviour:
- Interface:
  - One clock (clk).
  - Reset (reset) is asynchronous, active-low.
  - While reset is low, all registers clear, the FSM goes to IDLE, and every output is 0.
- States: IDLE, CALC, SIGN, DONE.
- Accept:
  - start is accepted only in IDLE or DONE.
  - start in CALC or SIGN is ignored; the in-flight operation and outputs are unaffected.
  - On acceptance at edge k:
    - capture the operand signs;
    - latch magnitudes as unsigned WIDTH bits (the most-negative value has magnitude 2^(WIDTH-1));
    - clear the partial remainder (WIDTH+1 bits) and the iteration counter;
    - clear div_by_zero and overflow.
- Normal path:
  - IDLE/DONE -> CALC at edge k.
  - CALC performs one iteration per edge, at edges k+1 .. k+WIDTH:
    - shift {partial remainder, quotient magnitude} left by 1, bringing in the next dividend MSB;
    - trial-subtract the divisor magnitude;
    - if the result is non-negative, keep it and set quotient bit 1; otherwise restore and set quotient bit 0.
  - The counter reaches WIDTH-1 on the last iteration; CALC -> SIGN.
  - SIGN, at edge k+WIDTH+1:
    - quotient = negated magnitude if the operand signs differ;
    - remainder = negated magnitude if the dividend is negative;
    - all values are truncated to WIDTH bits and registered on the outputs;
    - SIGN -> DONE.
  - DONE: done=1 for exactly one cycle, so done samples high at edge k+WIDTH+2 (18 cycles for WIDTH=16).
  - DONE -> IDLE unless start is high, which begins a new operation directly.
- busy timing: high in CALC and SIGN, i.e. high at edges k+1 .. k+WIDTH+1; low in IDLE and DONE.
- Output hold:
  - quotient, remainder, div_by_zero and overflow hold their values until the SIGN (or zero-divisor) update of the next operation.
  - They are not cleared by returning to IDLE.
- Divide by zero: if the captured divisor is 0 at acceptance edge k:
  - skip CALC and SIGN and go straight to DONE;
  - quotient = all ones (-1), remainder = dividend, div_by_zero = 1;
  - done samples high at edge k+1; busy stays 0.
- Overflow:
  - dividend = 100..0 and divisor = all ones completes the normal path;
  - quotient = 100..0 (the wrapped +2^(WIDTH-1)), remainder = 0, overflow = 1.
- Zero dividend: normal latency; quotient = 0, remainder = 0, no flags.
- Reset mid-operation: asserting reset at any cycle aborts immediately, with all outputs 0 and the FSM in IDLE. No done is produced for the aborted operation.
- Arithmetic: negation is the two's complement of WIDTH-bit values. Negating 100..0 yields 100..0, which is only possible in the overflow case.

Test Plan:
- 100 / 7: start at edge k -> done samples high only at edge k+18; quotient=0x000E, remainder=0x0002; busy high at edges k+1..k+17.
- -100 / 7 -> quotient=0xFFF2, remainder=0xFFFE. 100 / -7 -> quotient=0xFFF2, remainder=0x0002. -100 / -7 -> quotient=0x000E, remainder=0xFFFE.
- 1234 / 0 -> done at edge k+1; quotient=0xFFFF, remainder=0x04D2, div_by_zero=1, busy never high. A following 10 / 3 -> quotient=0x0003, remainder=0x0001, div_by_zero=0.
- 0x8000 / 0xFFFF -> quotient=0x8000, remainder=0x0000, overflow=1. 0x8000 / 0x0002 -> quotient=0xC000, remainder=0, overflow=0.
- Start 100 / 7; pulse start with 50 / 5 at edge k+5 -> ignored, result 0x000E / 0x0002 at edge k+18. Start asserted in the DONE cycle with 9 / 4 -> quotient=0x0002, remainder=0x0001 eighteen cycles later.
- Start 1000 / 3; drive reset low at edge k+8 -> all outputs 0 and busy=0 immediately; after release, no done pulse. A new 1000 / 3 -> quotient=0x014D, remainder=0x0001.
